pic_control_seq: RTL and testbench

PIC_CONTROL_SEQ -- requirements
Module: pic_control_seq

---
 rtl/pic_control_seq.sv | 131 +++++++++++++
 tb/tb_pic_control_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_control_seq.sv
// 8259-style PIC control sequencer: ICW1-4 init sequence, OCW1-3 handling
// and the two-pulse INTA acknowledge tracker.
module pic_control_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic       A0,
  input  logic [7:0] din,
  input  logic       inta_n,
  input  logic       int_req,
  output logic       endOfinit,
  output logic       LTIM,
  output logic       SNGL,
  output logic       ICW4,
  output logic [4:0] vector,
  output logic [7:0] ICW3,
  output logic [7:0] IMR,
  output logic [2:0] OCW2,
  output logic [1:0] RR_RIS,
  output logic       OCW2Sent,
  output logic       imp1,
  output logic       endOfimp1,
  output logic       imp2,
  output logic       endOfimp2,
  output logic       INT
);

  typedef enum logic [1:0] {READY, W_ICW2, W_ICW3, W_ICW4} init_st_t;
  typedef enum logic [1:0] {A_IDLE, A_P1, A_GAP, A_P2} ack_st_t;

  init_st_t init_st;
  ack_st_t  ack_st;
  logic     ic4;
  logic     inta_d;
  logic     icw1, fall, rise;

  // ICW1 restarts initialisation from any state
  assign icw1 = wr & ~A0 & din[4];
  assign fall = inta_d & ~inta_n;
  assign rise = ~inta_d & inta_n;
  assign INT  = int_req & endOfinit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_st   <= W_ICW2;
      endOfinit <= 1'b0;
      LTIM      <= 1'b0;
      SNGL      <= 1'b0;
      ICW4      <= 1'b0;
      ic4       <= 1'b0;
      vector    <= '0;
      ICW3      <= '0;
      IMR       <= '0;
      OCW2      <= '0;
      RR_RIS    <= 2'b10;
      OCW2Sent  <= 1'b0;
    end else begin
      OCW2Sent <= 1'b0;
      if (icw1) begin
        ic4       <= din[0];
        SNGL      <= din[1];
        LTIM      <= din[3];
        IMR       <= '0;
        ICW4      <= 1'b0;
        endOfinit <= 1'b0;
        RR_RIS    <= 2'b10;
        init_st   <= W_ICW2;
      end else if (wr) begin
        unique case (init_st)
          W_ICW2: if (A0) begin
            vector <= din[7:3];
            if (!SNGL) init_st <= W_ICW3;
            else if (ic4) init_st <= W_ICW4;
            else begin
              init_st   <= READY;
              endOfinit <= 1'b1;
            end
          end
          W_ICW3: if (A0) begin
            ICW3 <= din;
            if (ic4) init_st <= W_ICW4;
            else begin
              init_st   <= READY;
              endOfinit <= 1'b1;
            end
          end
          W_ICW4: if (A0) begin
            ICW4      <= din[1];
            init_st   <= READY;
            endOfinit <= 1'b1;
          end
          READY: begin
            // din[4]=1 with A0=0 is ICW1, so only OCW2/OCW3 remain here
            if (A0) IMR <= din;
            else if (din[4:3] == 2'b00) begin
              OCW2     <= din[7:5];
              OCW2Sent <= 1'b1;
            end else if (din[1]) RR_RIS <= din[1:0];
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_st    <= A_IDLE;
      inta_d    <= 1'b1;
      imp1      <= 1'b0;
      endOfimp1 <= 1'b0;
      imp2      <= 1'b0;
      endOfimp2 <= 1'b0;
    end else begin
      inta_d    <= inta_n;
      imp1      <= 1'b0;
      endOfimp1 <= 1'b0;
      imp2      <= 1'b0;
      endOfimp2 <= 1'b0;
      if (icw1) ack_st <= A_IDLE;
      else begin
        unique case (ack_st)
          A_IDLE: if (fall && endOfinit) begin imp1 <= 1'b1;      ack_st <= A_P1;   end
          A_P1:   if (rise)              begin endOfimp1 <= 1'b1; ack_st <= A_GAP;  end
          A_GAP:  if (fall)              begin imp2 <= 1'b1;      ack_st <= A_P2;   end
          A_P2:   if (rise)              begin endOfimp2 <= 1'b1; ack_st <= A_IDLE; end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_control_seq.sv
// Bench for pic_control_seq: directed init/OCW/INTA scenarios then random
// traffic against a behavioural model; pulses are checked via an event queue.
module tb_pic_control_seq;

  logic       clk = 1'b0;
  logic       rst_n, wr, A0, inta_n, int_req;
  logic [7:0] din;
  logic       endOfinit, LTIM, SNGL, ICW4;
  logic [4:0] vector;
  logic [7:0] ICW3, IMR;
  logic [2:0] OCW2;
  logic [1:0] RR_RIS;
  logic       OCW2Sent, imp1, endOfimp1, imp2, endOfimp2, INT;

  pic_control_seq dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .A0(A0), .din(din), .inta_n(inta_n),
    .int_req(int_req), .endOfinit(endOfinit), .LTIM(LTIM), .SNGL(SNGL),
    .ICW4(ICW4), .vector(vector), .ICW3(ICW3), .IMR(IMR), .OCW2(OCW2),
    .RR_RIS(RR_RIS), .OCW2Sent(OCW2Sent), .imp1(imp1), .endOfimp1(endOfimp1),
    .imp2(imp2), .endOfimp2(endOfimp2), .INT(INT)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // pulse codes: 0 OCW2Sent, 1 imp1, 2 endOfimp1, 3 imp2, 4 endOfimp2
  typedef struct { int code; int cyc; } ev_t;
  ev_t evq[$];

  // model: m_next is the ICW number awaited (2..4), 0 once initialised;
  // m_npulse counts acknowledge pulses already emitted in the current sequence
  int         m_next, m_npulse;
  bit         m_ic4, m_sngl, m_ltim, m_icw4, m_eoi, m_inta_d, m_ir;
  logic [4:0] m_vec;
  logic [7:0] m_icw3, m_imr;
  logic [2:0] m_ocw2;
  logic [1:0] m_rr;
  bit         cur_ia;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int code);
    ev_t e;
    e.code = code;
    e.cyc  = cyc + 1;
    evq.push_back(e);
  endtask

  task automatic check_all();
    cmp("endOfinit", endOfinit, m_eoi);
    cmp("LTIM", LTIM, m_ltim);
    cmp("SNGL", SNGL, m_sngl);
    cmp("ICW4", ICW4, m_icw4);
    cmp("vector", vector, m_vec);
    cmp("ICW3", ICW3, m_icw3);
    cmp("IMR", IMR, m_imr);
    cmp("OCW2", OCW2, m_ocw2);
    cmp("RR_RIS", RR_RIS, m_rr);
    cmp("INT", INT, m_ir & m_eoi);
  endtask

  // One clock: drive at a falling edge, advance the model, wait a cycle, check.
  task automatic step(input bit r, input bit w, input bit a, input logic [7:0] d,
                      input bit ia, input bit ir);
    bit icw1, fall, rise, edge_ok;
    rst_n = ~r; wr = w; A0 = a; din = d; inta_n = ia; int_req = ir;
    cur_ia = ia;
    m_ir = ir;
    if (r) begin
      m_next = 2; m_npulse = 0; m_ic4 = 0; m_sngl = 0; m_ltim = 0; m_icw4 = 0;
      m_eoi = 0; m_vec = 0; m_icw3 = 0; m_imr = 0; m_ocw2 = 0; m_rr = 2'b10;
      m_inta_d = 1;
    end else begin
      icw1 = w && !a && d[4];
      fall = m_inta_d && !ia;
      rise = !m_inta_d && ia;
      // even pulse counts wait for a falling INTA, odd ones for a rising one
      edge_ok = (m_npulse % 2 == 0) ? (fall && (m_npulse != 0 || m_eoi)) : rise;
      if (icw1) begin
        m_npulse = 0;
        m_ic4 = d[0]; m_sngl = d[1]; m_ltim = d[3];
        m_imr = 0; m_icw4 = 0; m_eoi = 0; m_rr = 2'b10; m_next = 2;
      end else if (w) begin
        if (m_next == 0) begin
          if (a) m_imr = d;
          else if (d[4:3] == 2'b00) begin m_ocw2 = d[7:5]; push(0); end
          else if (d[1]) m_rr = d[1:0];
        end else if (a) begin
          if (m_next == 2) begin
            m_vec = d[7:3];
            m_next = !m_sngl ? 3 : (m_ic4 ? 4 : 0);
          end else if (m_next == 3) begin
            m_icw3 = d;
            m_next = m_ic4 ? 4 : 0;
          end else begin
            m_icw4 = d[1];
            m_next = 0;
          end
          if (m_next == 0) m_eoi = 1;
        end
      end
      if (!icw1 && edge_ok) begin
        push(m_npulse + 1);
        m_npulse = (m_npulse + 1) % 4;
      end
      m_inta_d = ia;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic wrt(input bit a, input logic [7:0] d);
    step(0, 1, a, d, cur_ia, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 8'h00, cur_ia, 0);
  endtask

  task automatic ack_phase(input bit ia);
    step(0, 0, 0, 8'h00, ia, 0);
    idle(2);
  endtask

  always @(negedge clk) begin
    logic [4:0] p;
    if (mon_en) begin
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        checks++; errors++;
        $display("FAIL pulse_missing: code %0d expected at cycle %0d, absent", evq[0].code, evq[0].cyc);
        void'(evq.pop_front());
      end
      p = {endOfimp2, imp2, endOfimp1, imp1, OCW2Sent};
      for (int k = 0; k < 5; k++) begin
        if (p[k] === 1'b1) begin
          checks++;
          if (evq.size() > 0 && evq[0].cyc == cyc && evq[0].code == k) void'(evq.pop_front());
          else begin
            errors++;
            $display("FAIL pulse_unexpected: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                     k, cyc, evq.size() ? evq[0].code : -1, evq.size() ? evq[0].cyc : -1);
          end
        end
      end
    end
  end

  initial begin
    bit r, w, a, ia;
    logic [7:0] d;
    rst_n = 0; wr = 0; A0 = 0; din = 0; inta_n = 1; int_req = 0; cur_ia = 1;
    @(negedge clk);
    step(1, 0, 0, 8'h00, 1, 1);
    mon_en = 1'b1;
    step(1, 0, 0, 8'h00, 1, 0);
    cmp("rst_RR_RIS", RR_RIS, 2'b10);
    cmp("rst_endOfinit", endOfinit, 0);

    // single mode, no ICW4
    wrt(0, 8'h1A);
    cmp("s_endOfinit_early", endOfinit, 0);
    wrt(1, 8'h08);
    cmp("s_SNGL", SNGL, 1);
    cmp("s_LTIM", LTIM, 1);
    cmp("s_vector", vector, 5'b00001);
    cmp("s_endOfinit", endOfinit, 1);

    // cascade with ICW3 and ICW4
    wrt(0, 8'h11);
    wrt(1, 8'h20);
    wrt(1, 8'h04);
    cmp("c_endOfinit_before_icw4", endOfinit, 0);
    wrt(1, 8'h02);
    cmp("c_ICW3", ICW3, 8'h04);
    cmp("c_ICW4", ICW4, 1);
    cmp("c_vector", vector, 5'b00100);
    cmp("c_endOfinit", endOfinit, 1);

    // full acknowledge sequence, 3-cycle phases
    ack_phase(0); ack_phase(1); ack_phase(0); ack_phase(1);

    // OCWs in READY
    wrt(1, 8'hF0);
    cmp("o_IMR", IMR, 8'hF0);
    wrt(0, 8'h20);
    cmp("o_OCW2", OCW2, 3'b001);
    idle(1);
    wrt(0, 8'h0B);
    cmp("o_RR_RIS", RR_RIS, 2'b11);
    wrt(0, 8'h08);
    cmp("o_RR_RIS_hold", RR_RIS, 2'b11);

    // ICW1 in the gap between the two INTA pulses
    ack_phase(0); ack_phase(1);
    wrt(0, 8'h1A);
    cmp("g_endOfinit", endOfinit, 0);
    cmp("g_IMR", IMR, 8'h00);
    ack_phase(0); ack_phase(1);
    wrt(1, 8'h08);

    // reset during the first INTA pulse
    ack_phase(0);
    step(1, 0, 0, 8'h00, 0, 1);
    cmp("r_INT", INT, 0);
    cmp("r_endOfinit", endOfinit, 0);
    ack_phase(0); ack_phase(1);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, 1);
      d  = 8'($urandom);
      if (!a && d[4] && $urandom_range(0, 3) != 0) d[4] = 1'b0;
      ia = ($urandom_range(0, 2) == 0) ? ~cur_ia : cur_ia;
      step(r, w, a, d, ia, 1'($urandom_range(0, 1)));
    end

    idle(3);
    cmp("events_drained", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
